// File: rtl/rmii_rx.sv
// RMII receive path: dibit-to-byte assembly with preamble/SFD qualification,
// LAN8720-style CRS_DV end-of-frame toggling tolerance and frame status pulses.
module rmii_rx #(
  parameter int unsigned MIN_PREAMBLE_DIBITS = 4,
  parameter int unsigned MAX_FRAME_BYTES     = 1530
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] rmii_rxd,
  input  logic       rmii_crs_dv,
  input  logic       rmii_rx_er,
  output logic [7:0] received_byte,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       frame_err
);

  localparam int unsigned BCW = $clog2(MAX_FRAME_BYTES + 1);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t         state_q, state_d;
  logic           crs_prev_q;
  logic [4:0]     pcnt_q, pcnt_d;
  logic [1:0]     dcnt_q, dcnt_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     byte_q, byte_d;
  logic           err_q, err_d;
  logic           bv_q, bv_d, fs_q, fs_d, fe_q, fe_d, ferr_q, ferr_d;
  logic           eoc;

  // A lone low CRS_DV cycle is mid-frame toggling; two in a row end the frame.
  assign eoc = !rmii_crs_dv && !crs_prev_q;

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    dcnt_d  = dcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    err_d   = err_q;
    bv_d    = 1'b0;
    fs_d    = 1'b0;
    fe_d    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rmii_crs_dv) begin
          if (rmii_rxd == 2'b01) begin
            state_d = PREAMBLE;
            pcnt_d  = 5'd1;
          end else if (rmii_rxd[1]) begin
            state_d = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (eoc) begin
          state_d = IDLE;
        end else if (rmii_rxd == 2'b01) begin
          if (pcnt_q != 5'd31) pcnt_d = pcnt_q + 5'd1;
        end else if (rmii_rxd == 2'b11 && {27'd0, pcnt_q} >= MIN_PREAMBLE_DIBITS) begin
          state_d = DATA;
          byte_d  = 8'hD5;
          bv_d    = 1'b1;
          fs_d    = 1'b1;
          dcnt_d  = '0;
          bcnt_d  = BCW'(1);
          shift_d = '0;
          err_d   = 1'b0;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (eoc) begin
          // Dibit count 1 means only the discarded first-low-cycle dibit followed the last byte.
          state_d = IDLE;
          fe_d    = 1'b1;
          ferr_d  = (dcnt_q != 2'd1) || err_q || rmii_rx_er;
          err_d   = 1'b0;
        end else begin
          err_d   = err_q | rmii_rx_er;
          shift_d = {rmii_rxd, shift_q[7:2]};
          dcnt_d  = dcnt_q + 2'd1;
          if (dcnt_q == 2'd3) begin
            if (32'(bcnt_q) >= MAX_FRAME_BYTES) begin
              state_d = DROP;
              fe_d    = 1'b1;
              ferr_d  = 1'b1;
              err_d   = 1'b0;
            end else begin
              byte_d = shift_d;
              bv_d   = 1'b1;
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (eoc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      crs_prev_q <= 1'b0;
      pcnt_q     <= '0;
      dcnt_q     <= '0;
      bcnt_q     <= '0;
      shift_q    <= '0;
      byte_q     <= '0;
      err_q      <= 1'b0;
      bv_q       <= 1'b0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      crs_prev_q <= rmii_crs_dv;
      pcnt_q     <= pcnt_d;
      dcnt_q     <= dcnt_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      byte_q     <= byte_d;
      err_q      <= err_d;
      bv_q       <= bv_d;
      fs_q       <= fs_d;
      fe_q       <= fe_d;
      ferr_q     <= ferr_d;
    end
  end

  assign received_byte = byte_q;
  assign byte_valid    = bv_q;
  assign frame_start   = fs_q;
  assign frame_end     = fe_q;
  assign frame_err     = ferr_q;

endmodule

// File: doc/rmii_rx.md
RMII_RX -- requirements
Module: rmii_rx

Interface
REQ-001 The module SHALL have parameter MIN_PREAMBLE_DIBITS, default 4: the minimum number of 01 dibits that must precede the 11 SFD-closing dibit.
REQ-002 The module SHALL have parameter MAX_FRAME_BYTES, default 1530: the maximum number of bytes emitted per frame, counting the SFD byte.
REQ-003 Ports SHALL be exactly as listed in REQ-004..REQ-013; one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  50 MHz LAN8720 reference clock.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 rmii_rxd  in  2  RMII receive dibit; bit 0 is the earlier bit on the wire.
REQ-007 rmii_crs_dv  in  1  carrier sense / data valid from the PHY.
REQ-008 rmii_rx_er  in  1  PHY receive error.
REQ-009 received_byte  out  8  assembled byte, LSB first on the wire.
REQ-010 byte_valid  out  1  one-cycle pulse, received_byte valid.
REQ-011 frame_start  out  1  pulse coincident with the SFD byte (0xD5).
REQ-012 frame_end  out  1  one-cycle pulse at frame termination.
REQ-013 frame_err  out  1  pulse coincident with frame_end when the frame is bad.

Function
REQ-014 Inputs SHALL be sampled on rising clk edges: one dibit per cycle.
REQ-015 End condition (EOC) SHALL be rmii_crs_dv low in the current cycle AND in the previous cycle. A single low cycle, as in LAN8720 end-of-frame toggling, SHALL NOT end a frame, and its dibit SHALL be accepted as data.
REQ-016 The state machine SHALL have exactly the states IDLE, PREAMBLE, DATA and DROP.
REQ-017 IDLE transitions:
- crs_dv=1 and rxd=01 -> PREAMBLE, preamble count = 1.
- crs_dv=1 and rxd=00 -> stay in IDLE.
- crs_dv=1 and rxd=10 or 11 -> DROP.
REQ-018 PREAMBLE transitions:
- rxd=01 -> increment count, saturating at 31.
- rxd=11 with count >= MIN_PREAMBLE_DIBITS -> emit 0xD5 with byte_valid and frame_start, then DATA with dibit count 0 and byte count 1.
- rxd=11 with count < MIN, or rxd=00/10 -> DROP.
- EOC -> IDLE with no pulses.
REQ-019 DATA shall shift each accepted dibit in as received_byte_shift <= {rxd, shift[7:2]}. On the 4th dibit, byte_valid SHALL pulse the following cycle with the full byte, and the byte count SHALL increment.
REQ-020 Consecutive byte_valid pulses in DATA SHALL be spaced exactly 4 cycles apart.
REQ-021 DATA end handling:
- EOC in DATA -> frame_end next cycle, then IDLE. The dibit accepted in the first low cycle is discarded.
- frame_err SHALL be 1 if the dibit count at EOC is not 1, or if rx_er was seen.
- A partial byte SHALL never be emitted.
REQ-022 rx_er=1 in any DATA cycle SHALL set a sticky error flag, cleared on leaving DATA. No byte SHALL be suppressed because of it.
REQ-023 If byte count would exceed MAX_FRAME_BYTES, that byte SHALL NOT be emitted. Instead frame_end and frame_err SHALL pulse, and the state SHALL go to DROP.
REQ-024 DROP SHALL produce no output pulses and SHALL go to IDLE on EOC.
REQ-025 frame_end SHALL never coincide with byte_valid. received_byte SHALL hold its last value between pulses.

Reset
REQ-026 resetn low SHALL immediately force state IDLE and zero received_byte, byte_valid, frame_start, frame_end, frame_err, all counters and the error flag.
REQ-027 Reset mid-frame SHALL discard the frame with no frame_end. Reception SHALL resume from IDLE on the next preamble after resetn rises.

Verification
REQ-028 7x 0x55, 0xD5, 0x00, 0x1A, 0x2B, then crs_dv low -> byte_valid bytes D5,00,1A,2B at 4-cycle spacing; frame_start on D5; frame_end once; frame_err=0.
REQ-029 Same frame with crs_dv toggling low/high per dibit during the last 2 bytes -> identical bytes, no early frame_end, frame_err=0.
REQ-030 MIN=4, dibits 01,01,11 -> no byte_valid; DROP until EOC; next valid frame received correctly.
REQ-031 rx_er pulse during byte 2 -> all bytes still emitted; frame_end with frame_err=1.
REQ-032 Frame with 2 extra dibits after the last byte -> partial byte not emitted; frame_err=1.
REQ-033 MAX_FRAME_BYTES=8, 12-byte frame -> 8 byte_valid, then frame_end+frame_err, DROP; resetn pulse mid-frame -> all outputs 0, no frame_end.
